wb_regfile_stage: RTL

Writeback stage and architectural register file for the SIMD AES pipeline. It consumes the 34-bit packed bus produced by the MEM/WB pipeline register and selects memory data or ALU result. It writes that value into a 16 x 16-bit register file and serves two combinational read ports, with write-through bypass, to the decode stage. A busy-bit scoreboard generates the decode stall for RAW and WAW hazards, and a retire counter plus a registered trace port support verification.

---
 rtl/aes_pipe_pkg.sv | 27 ++
 rtl/wb_regfile_stage_if.sv | 27 ++
 rtl/wb_scoreboard.sv | 30 +++
 rtl/wb_regfile_stage.sv | 63 ++++++
 4 files changed

// File: rtl/aes_pipe_pkg.sv
// Shared definitions for the SIMD AES pipeline: MEM/WB bus layout, sizes and
// register-file types.
package aes_pipe_pkg;
    localparam int NREG = 16;
    localparam int DW   = 16;
    localparam int MEMW = 12;
    localparam int AW   = 4;

    localparam int MEMWB_MEMRD   = 33;
    localparam int MEMWB_WB      = 32;
    localparam int MEMWB_DEST_HI = 31;
    localparam int MEMWB_DEST_LO = 28;
    localparam int MEMWB_ALU_HI  = 27;
    localparam int MEMWB_ALU_LO  = 12;
    localparam int MEMWB_DATO_HI = 11;
    localparam int MEMWB_DATO_LO = 0;

    typedef logic [AW-1:0] reg_addr_t;
    typedef logic [DW-1:0] data_t;

    function automatic logic [NREG-1:0] onehot(reg_addr_t a);
        logic [NREG-1:0] r;
        r    = '0;
        r[a] = 1'b1;
        return r;
    endfunction
endpackage

// File: rtl/wb_regfile_stage_if.sv
// Decode/writeback-facing signal bundle of the writeback stage; master is the
// pipeline side that drives the bus and decode requests.
interface wb_regfile_stage_if;
    import aes_pipe_pkg::*;
    logic [MEMWB_MEMRD:0] mem_wb_in;
    reg_addr_t            rs1_addr;
    reg_addr_t            rs2_addr;
    data_t                rs1_data;
    data_t                rs2_data;
    logic                 issue_valid;
    logic                 issue_writes;
    reg_addr_t            issue_dest;
    logic                 stall;
    logic [15:0]          retire_count;
    logic                 wb_valid;
    reg_addr_t            wb_dest;
    data_t                wb_data;

    modport master (
        output mem_wb_in, rs1_addr, rs2_addr, issue_valid, issue_writes, issue_dest,
        input  rs1_data, rs2_data, stall, retire_count, wb_valid, wb_dest, wb_data
    );
    modport slave (
        input  mem_wb_in, rs1_addr, rs2_addr, issue_valid, issue_writes, issue_dest,
        output rs1_data, rs2_data, stall, retire_count, wb_valid, wb_dest, wb_data
    );
endinterface

// File: rtl/wb_scoreboard.sv
// Busy-bit scoreboard: tracks registers with an outstanding producer and
// stalls decode on RAW/WAW hazards against them.
module wb_scoreboard
    import aes_pipe_pkg::*;
(
    input  logic      clock,
    input  logic      reset,
    input  logic      we,
    input  reg_addr_t wdest,
    input  logic      issue_valid,
    input  logic      issue_writes,
    input  reg_addr_t issue_dest,
    input  reg_addr_t rs1_addr,
    input  reg_addr_t rs2_addr,
    output logic      stall
);
    logic [NREG-1:0] busy, clr, set, eff;

    // A register retiring this cycle is already free: bypass covers its value.
    assign clr   = we ? onehot(wdest) : '0;
    assign eff   = busy & ~clr;
    assign stall = issue_valid && (eff[rs1_addr] || eff[rs2_addr] ||
                                   (issue_writes && eff[issue_dest]));
    assign set   = (issue_valid && issue_writes && !stall) ? onehot(issue_dest) : '0;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) busy <= '0;
        else       busy <= eff | set;
    end
endmodule

// File: rtl/wb_regfile_stage.sv
// Writeback stage: selects memory/ALU result, writes the register file, serves
// two bypassed read ports, and exposes a retire counter and trace port.
module wb_regfile_stage
    import aes_pipe_pkg::*;
#(
    parameter int NREG = aes_pipe_pkg::NREG,
    parameter int DW   = aes_pipe_pkg::DW,
    parameter int MEMW = aes_pipe_pkg::MEMW
) (
    input  logic               clock,
    input  logic               reset,
    wb_regfile_stage_if.slave  bif
);
    logic            we, wsel;
    reg_addr_t       wdest;
    logic [DW-1:0]   wdata;
    logic [DW-1:0]   regs [NREG];

    assign we    = bif.mem_wb_in[MEMWB_WB];
    assign wsel  = bif.mem_wb_in[MEMWB_MEMRD];
    assign wdest = bif.mem_wb_in[MEMWB_DEST_HI:MEMWB_DEST_LO];
    // Memory data is zero-extended to the register width.
    assign wdata = wsel ? {{(DW-MEMW){1'b0}}, bif.mem_wb_in[MEMWB_DATO_HI:MEMWB_DATO_LO]}
                        : bif.mem_wb_in[MEMWB_ALU_HI:MEMWB_ALU_LO];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (we) begin
            regs[wdest] <= wdata;
        end
    end

    assign bif.rs1_data = (we && wdest == bif.rs1_addr) ? wdata : regs[bif.rs1_addr];
    assign bif.rs2_data = (we && wdest == bif.rs2_addr) ? wdata : regs[bif.rs2_addr];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bif.retire_count <= '0;
            bif.wb_valid     <= 1'b0;
            bif.wb_dest      <= '0;
            bif.wb_data      <= '0;
        end else begin
            if (we) bif.retire_count <= bif.retire_count + 16'd1;
            bif.wb_valid <= we;
            bif.wb_dest  <= wdest;
            bif.wb_data  <= wdata;
        end
    end

    wb_scoreboard u_sb (
        .clock       (clock),
        .reset       (reset),
        .we          (we),
        .wdest       (wdest),
        .issue_valid (bif.issue_valid),
        .issue_writes(bif.issue_writes),
        .issue_dest  (bif.issue_dest),
        .rs1_addr    (bif.rs1_addr),
        .rs2_addr    (bif.rs2_addr),
        .stall       (bif.stall)
    );
endmodule
